entry_seq_ctrl: RTL
===================

ENTRY_SEQ_CTRL -- requirements
Module: entry_seq_ctrl

Interface
REQ-001 SHALL have parameter NUM_MAX, default 9: largest digit value before num wraps to 0.
REQ-002 SHALL have parameter SCAN_DIV, default 16: display-refresh request period in clock cycles (>=8).
REQ-003 SHALL have port CLOCK_50  input  1: sole clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1: synchronous, active-high reset.
REQ-005 SHALL have port KEY  input  2: KEY[1] = digit increment, KEY[0] = position advance; high = pressed; asynchronous to CLOCK_50.
REQ-006 SHALL have port ram_we  output  1: registered write strobe to a shared 16x4 single-port RAM.
REQ-007 SHALL have port ram_addr  output  4: registered RAM address, used for both write and read.
REQ-008 SHALL have port ram_wdata  output  4: registered RAM write data.
REQ-009 SHALL have port ram_rdata  input  4: RAM read data, valid one cycle after ram_addr is presented.
REQ-010 SHALL have port num  output  4: digit currently being edited.
REQ-011 SHALL have port addr  output  4: cursor position, i.e. the RAM word the next commit writes.
REQ-012 SHALL have port disp  output  24: six refreshed RAM nibbles; disp[4k+3:4k] = RAM[base+k].
REQ-013 SHALL have port busy  output  1: high whenever the FSM is not IDLE.

Function
REQ-014 SHALL pass each KEY bit through a 2-flop synchronizer and a rising-edge detector, giving a 1-cycle pulse (inc_p, adv_p) per press.
REQ-015 SHALL latch each pulse into a one-deep pending flag (inc_pend, adv_pend), cleared when serviced; a repeat pulse while its flag is set is lost.
REQ-016 SHALL service inc_pend in any state within one cycle: num <= (num==NUM_MAX) ? 0 : num+1.
REQ-017 SHALL, when inc_p/inc_pend and adv_p/adv_pend are present in the same cycle that adv is serviced, discard the increment.
REQ-018 SHALL implement FSM states IDLE, COMMIT and SCAN.
REQ-019 SHALL, in IDLE with adv_pend set, enter COMMIT; this takes priority over scan_req.
REQ-020 SHALL, on entering COMMIT, drive ram_we=1, ram_addr=addr and ram_wdata=num for exactly one cycle, then return to IDLE.
REQ-021 SHALL, on leaving COMMIT, set addr <= addr+1 mod 16 (15 wraps to 0) and num <= 0.
REQ-022 SHALL run a free-running scan timer that sets scan_req every SCAN_DIV cycles; scan_req stays set until SCAN is entered.
REQ-023 SHALL, in IDLE with scan_req set and no adv_pend, enter SCAN and compute base = (addr<6) ? 0 : addr-5, frozen for the whole scan.
REQ-024 SHALL, in SCAN, issue read addresses base..base+5 on consecutive cycles with ram_we=0, capture ram_rdata one cycle after each into its disp nibble, and return to IDLE after the 7th cycle.
REQ-025 SHALL not update disp in any state except SCAN.
REQ-026 SHALL not preempt a SCAN; an adv arriving during SCAN stays pending and commits on the first cycle back in IDLE.
REQ-027 SHALL keep ram_we low in every state except the COMMIT cycle.

Reset
REQ-028 SHALL, on reset, force num=0, addr=0, disp=0, ram_we=0, ram_addr=0, ram_wdata=0 and busy=0.
REQ-029 SHALL, on reset, clear the FSM to IDLE and clear the pending flags, scan timer, scan_req and synchronizer/edge registers.
REQ-030 SHALL, on reset asserted mid-COMMIT or mid-SCAN, abort the operation at the next edge with no further RAM write and disp left at 0.

Verification
REQ-031 SHALL cover: reset, then 3 KEY[1] presses -> num=3, addr=0, ram_we never high.
REQ-032 SHALL cover: 10 KEY[1] presses from reset -> num counts 1..9, then wraps to 0.
REQ-033 SHALL cover: num=2, addr=0, KEY[0] press -> one cycle with ram_we=1, ram_addr=0, ram_wdata=2; then addr=1, num=0.
REQ-034 SHALL cover: addr=15, num=5, KEY[0] press -> write 5 to address 15; then addr=0.
REQ-035 SHALL cover: num=4, KEY[1] and KEY[0] rising in the same cycle -> RAM receives 4 and num ends at 0 (increment dropped).
REQ-036 SHALL cover: RAM[0]=2, RAM[1]=4, addr=2, one SCAN -> disp=24'h000042; KEY[0] pressed during SCAN -> ram_we delayed until the cycle after SCAN ends.

Source files
------------

// File: rtl/entry_seq_ctrl.sv
// Digit-entry sequencer: edits a digit with two keys and commits it to a shared 16x4 RAM.
// It also periodically scans a six-word window of that RAM into the display register.
module entry_seq_ctrl #(
    parameter int NUM_MAX  = 9,
    parameter int SCAN_DIV = 16
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic [1:0]  KEY,
    output logic        ram_we,
    output logic [3:0]  ram_addr,
    output logic [3:0]  ram_wdata,
    input  logic [3:0]  ram_rdata,
    output logic [3:0]  num,
    output logic [3:0]  addr,
    output logic [23:0] disp,
    output logic        busy
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] COMMIT = 2'd1;
    localparam logic [1:0] SCAN   = 2'd2;

    localparam int            TW         = $clog2(SCAN_DIV);
    localparam logic [TW-1:0] TIMER_LAST = TW'(SCAN_DIV - 1);
    localparam logic [3:0]    NUM_TOP    = 4'(NUM_MAX);

    logic [1:0]    key_s1, key_s2, key_d;
    logic          inc_p, adv_p;
    logic          inc_pend, adv_pend;
    logic [1:0]    state;
    logic [TW-1:0] scan_timer;
    logic          scan_req;
    logic [3:0]    base;
    logic [2:0]    scan_cnt;
    logic          start_commit, start_scan;
    logic [3:0]    scan_base_next;
    logic [3:0]    num_src;

    assign inc_p          = key_s2[1] & ~key_d[1];
    assign adv_p          = key_s2[0] & ~key_d[0];
    assign start_commit   = (state == IDLE) && adv_pend;
    assign start_scan     = (state == IDLE) && !adv_pend && scan_req;
    assign scan_base_next = (addr < 4'd6) ? 4'd0 : addr - 4'd5;
    assign num_src        = (state == COMMIT) ? 4'd0 : num;
    assign busy           = (state != IDLE);

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            key_s1 <= '0;
            key_s2 <= '0;
            key_d  <= '0;
        end else begin
            key_s1 <= KEY;
            key_s2 <= key_s1;
            key_d  <= key_s2;
        end
    end

    // An increment seen in the cycle a commit is taken is dropped so the committed digit is the one shown.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            inc_pend <= 1'b0;
            adv_pend <= 1'b0;
        end else begin
            inc_pend <= start_commit ? 1'b0 : inc_p;
            adv_pend <= start_commit ? 1'b0 : (adv_pend | adv_p);
        end
    end

    // A press landing during COMMIT counts toward the fresh digit rather than being lost.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            num  <= '0;
            addr <= '0;
        end else begin
            if (inc_pend && !start_commit)
                num <= (num_src == NUM_TOP) ? 4'd0 : num_src + 4'd1;
            else if (state == COMMIT)
                num <= 4'd0;
            if (state == COMMIT)
                addr <= addr + 4'd1;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            scan_timer <= '0;
            scan_req   <= 1'b0;
        end else begin
            scan_timer <= (scan_timer == TIMER_LAST) ? '0 : scan_timer + 1'b1;
            if (scan_timer == TIMER_LAST)
                scan_req <= 1'b1;
            else if (start_scan)
                scan_req <= 1'b0;
        end
    end

    // Scan cycle k presents base+k; the word read for cycle k arrives and is captured in cycle k+1.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state     <= IDLE;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            disp      <= '0;
            base      <= '0;
            scan_cnt  <= '0;
        end else begin
            ram_we <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_commit) begin
                        state     <= COMMIT;
                        ram_we    <= 1'b1;
                        ram_addr  <= addr;
                        ram_wdata <= num;
                    end else if (start_scan) begin
                        state    <= SCAN;
                        base     <= scan_base_next;
                        ram_addr <= scan_base_next;
                        scan_cnt <= '0;
                    end
                end
                COMMIT: state <= IDLE;
                SCAN: begin
                    if (scan_cnt < 3'd5)
                        ram_addr <= base + 4'(scan_cnt) + 4'd1;
                    case (scan_cnt)
                        3'd1:    disp[3:0]   <= ram_rdata;
                        3'd2:    disp[7:4]   <= ram_rdata;
                        3'd3:    disp[11:8]  <= ram_rdata;
                        3'd4:    disp[15:12] <= ram_rdata;
                        3'd5:    disp[19:16] <= ram_rdata;
                        3'd6:    disp[23:20] <= ram_rdata;
                        default: ;
                    endcase
                    if (scan_cnt == 3'd6)
                        state <= IDLE;
                    else
                        scan_cnt <= scan_cnt + 3'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
